// File: rtl/fetch_pkg.sv
// Shared types and constants for the sequential instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned          XLEN_DEF     = 32;
    localparam logic [31:0]          RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0]          NOP_INSTR    = 32'h0000_0013;

    // Decode field positions inside the 32-bit instruction word
    localparam int unsigned          OPCODE_LSB   = 0;
    localparam int unsigned          OPCODE_W     = 7;
    localparam int unsigned          FUNCT3_LSB   = 12;
    localparam int unsigned          FUNCT3_W     = 3;
    localparam int unsigned          FUNCT7_5_BIT = 30;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: sequential PC+4 or an aligned branch/jump target.
module pc_next_logic
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    // Unsigned add; carry out is discarded so the PC wraps at 2^XLEN
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        if (pc_src) begin
            next_pc  = pc_target;
            misalign = (pc_target[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM: owns the PC, issues one fetch at a time and hands the instruction to control.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] Instr,
    output logic [6:0]      OPCode,
    output logic [2:0]      function3,
    output logic            function7,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    input  logic            PCsrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            fetch_fault
);

    fetch_state_e    state;
    logic [XLEN-1:0] next_pc;
    logic            misalign;

    pc_next_logic #(
        .XLEN(XLEN)
    ) u_pc_next (
        .pc        (PC),
        .pc_src    (PCsrc),
        .pc_target (PCTarget),
        .pc_plus4  (PCPlus4),
        .next_pc   (next_pc),
        .misalign  (misalign)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            Instr       <= NOP_INSTR;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    // A response in the handshake cycle is illegal and ignored here
                    if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        Instr <= imem_rsp_data;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (misalign) begin
                        fetch_fault <= 1'b1;
                        state       <= FAULT;
                    end else begin
                        PC    <= next_pc;
                        state <= REQ;
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake strobes decode the state register only, so they never glitch
    assign imem_req_valid = (state == REQ);
    assign instr_valid    = (state == EXEC);
    assign imem_req_addr  = PC;

    assign OPCode    = Instr[OPCODE_LSB +: OPCODE_W];
    assign function3 = Instr[FUNCT3_LSB +: FUNCT3_W];
    assign function7 = Instr[FUNCT7_5_BIT];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected addresses/instructions queued at stimulus time.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [6:0]  OPCode;
    logic [2:0]  function3;
    logic        function7;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PCsrc;
    logic [31:0] PCTarget;
    logic        fetch_fault;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] model_pc;

    instr_fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .Instr          (Instr),
        .OPCode         (OPCode),
        .function3      (function3),
        .function7      (function7),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .PCsrc          (PCsrc),
        .PCTarget       (PCTarget),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resync_model();
        model_pc = 32'h0000_0000;
        exp_addr_q.delete();
        exp_instr_q.delete();
        exp_addr_q.push_back(model_pc);
    endtask

    // One full REQ/WAIT/EXEC transaction; stray responses are injected where they must be dropped
    task automatic do_fetch(input logic [31:0] data, input int unsigned ready_delay,
                            input int unsigned rsp_delay, input logic src,
                            input logic [31:0] tgt, input logic stray);
        int unsigned n;
        logic [31:0] ea;
        logic [31:0] ei;
        logic [31:0] held;
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        total++;
        if (imem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL req_timeout: valid=%b required=1", imem_req_valid);
            return;
        end
        total++;
        if (exp_addr_q.size() == 0) begin
            bad++;
            $display("FAIL addr_queue_empty: got addr=%h", imem_req_addr);
        end else begin
            ea = exp_addr_q.pop_front();
            if (imem_req_addr !== ea) begin
                bad++;
                $display("FAIL req_addr: got=%h required=%h", imem_req_addr, ea);
            end
        end
        held = imem_req_addr;
        imem_req_ready = 1'b0;
        for (int unsigned i = 0; i < ready_delay; i++) begin
            step();
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== held) begin
                bad++;
                $display("FAIL req_hold: valid=%b addr=%h required valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, held);
            end
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = stray;
        imem_rsp_data  = 32'hBAD0_0BAD;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        total++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL wait_entry: req_valid=%b instr_valid=%b required 0/0",
                     imem_req_valid, instr_valid);
        end
        for (int unsigned i = 0; i < rsp_delay; i++) begin
            step();
            total++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait_hold: req_valid=%b instr_valid=%b required 0/0",
                         imem_req_valid, instr_valid);
            end
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        exp_instr_q.push_back(data);
        step();
        imem_rsp_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL exec_strobe: instr_valid=%b required=1", instr_valid);
        end
        ei = exp_instr_q.pop_front();
        total++;
        if (Instr !== ei || OPCode !== ei[6:0] || function3 !== ei[14:12] || function7 !== ei[30]) begin
            bad++;
            $display("FAIL exec_instr: Instr=%h op=%h f3=%h f7=%b required Instr=%h op=%h f3=%h f7=%b",
                     Instr, OPCode, function3, function7, ei, ei[6:0], ei[14:12], ei[30]);
        end
        total++;
        if (PC !== model_pc || PCPlus4 !== model_pc + 32'd4) begin
            bad++;
            $display("FAIL exec_pc: PC=%h PCPlus4=%h required %h %h",
                     PC, PCPlus4, model_pc, model_pc + 32'd4);
        end
        PCsrc          = src;
        PCTarget       = tgt;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFEED_F00D;
        step();
        PCsrc          = 1'b0;
        PCTarget       = 32'h0;
        imem_rsp_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || Instr !== data) begin
            bad++;
            $display("FAIL post_exec: instr_valid=%b Instr=%h required 0 %h",
                     instr_valid, Instr, data);
        end
        if (!(src && tgt[1:0] != 2'b00)) begin
            model_pc = src ? tgt : model_pc + 32'd4;
            exp_addr_q.push_back(model_pc);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: req=%b iv=%b ff=%b required 0/0/0",
                     imem_req_valid, instr_valid, fetch_fault);
        end
        total++;
        if (Instr !== 32'h0000_0013 || PC !== 32'h0 || imem_req_addr !== 32'h0 || PCPlus4 !== 32'h4) begin
            bad++;
            $display("FAIL reset_regs: Instr=%h PC=%h addr=%h p4=%h required 13/0/0/4",
                     Instr, PC, imem_req_addr, PCPlus4);
        end
        reset_n = 1'b1;
        resync_model();
        step();
        total++;
        if (imem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL idle_to_req: req_valid=%b required=1", imem_req_valid);
        end
    endtask

    task automatic test_basic();
        do_fetch(32'h0000_0013, 0, 0, 1'b0, 32'h0, 1'b0);
        do_fetch(32'h0020_8133, 0, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_ready_stall();
        do_fetch(32'h4020_d0b3, 5, 2, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_branch();
        do_fetch(32'h0000_0463, 0, 0, 1'b1, 32'h0000_0100, 1'b0);
        do_fetch(32'h0000_0013, 0, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        do_fetch(32'h0000_006F, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        do_fetch(32'h0000_0013, 0, 1, 1'b0, 32'h0, 1'b0);
        do_fetch(32'h0000_0093, 0, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int unsigned i = 0; i < 4; i++) begin
            do_fetch($urandom, 0, 0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int unsigned n;
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n        = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        total++;
        if (Instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_wait_reset_instr: Instr=%h iv=%b required 13/0", Instr, instr_valid);
        end
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            bad++;
            $display("FAIL mid_wait_reset_req: valid=%b addr=%h required 1/0",
                     imem_req_valid, imem_req_addr);
        end
        resync_model();
        do_fetch(32'h0000_0013, 0, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_fault();
        logic [31:0] old_pc;
        old_pc = model_pc;
        do_fetch(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0102, 1'b0);
        total++;
        if (fetch_fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_flag: fetch_fault=%b required=1", fetch_fault);
        end
        for (int unsigned i = 0; i < 6; i++) begin
            imem_req_ready = 1'b1;
            step();
            total++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || PC !== old_pc || fetch_fault !== 1'b1) begin
                bad++;
                $display("FAIL fault_hold: req=%b iv=%b PC=%h ff=%b required 0/0/%h/1",
                         imem_req_valid, instr_valid, PC, fetch_fault, old_pc);
            end
        end
        imem_req_ready = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        total++;
        if (fetch_fault !== 1'b0 || PC !== 32'h0) begin
            bad++;
            $display("FAIL fault_clear: ff=%b PC=%h required 0/0", fetch_fault, PC);
        end
        resync_model();
        do_fetch(32'h0000_0013, 0, 0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        PCsrc          = 1'b0;
        PCTarget       = 32'h0;
        model_pc       = 32'h0;
        test_reset();
        test_basic();
        test_ready_stall();
        test_branch();
        test_wrap();
        test_back_to_back();
        test_reset_mid_wait();
        test_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction-fetch front end for the RISC-V core. It owns the program counter, fetches one instruction at a time from instruction memory over a valid/ready request channel and a valid response channel, and presents the instruction and its decode fields (OPCode, function3, function7) to the control unit. It then consumes the control unit's PCsrc decision and the datapath's branch/jump target to select the next PC. At most one fetch is outstanding at any time.

## Interface
- XLEN, 32, address/instruction width (only 32 supported)
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= PC)
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  XLEN  fetched instruction word
- instr_valid  out  1  one-cycle strobe: Instr executes this cycle
- Instr  out  XLEN  registered instruction word
- OPCode  out  7  Instr[6:0]
- function3  out  3  Instr[14:12]
- function7  out  1  Instr[30]
- PC  out  XLEN  address of Instr
- PCPlus4  out  XLEN  PC + 4, mod 2^32
- PCsrc  in  1  from control unit; valid only while instr_valid=1
- PCTarget  in  XLEN  branch/jump target; valid only while instr_valid=1
- fetch_fault  out  1  sticky misaligned-target flag

## Operation
- States: IDLE, REQ, WAIT, EXEC, FAULT.
- IDLE: entered on reset; always goes to REQ on the next cycle.
- REQ: imem_req_valid=1, imem_req_addr=PC. On imem_req_valid & imem_req_ready, go to WAIT. imem_rsp_valid is ignored in REQ.
- WAIT: on imem_rsp_valid, Instr <= imem_rsp_data and go to EXEC. Otherwise stay in WAIT (no timeout).
- EXEC: instr_valid=1 for exactly one cycle. The next PC is chosen as follows:
  - PCsrc=0: PC <= PC+4, go to REQ.
  - PCsrc=1 and PCTarget[1:0]==2'b00: PC <= PCTarget, go to REQ.
  - PCsrc=1 and PCTarget[1:0]!=0: PC unchanged, fetch_fault <= 1, go to FAULT.
- FAULT: terminal state. No requests are issued and instr_valid=0. Only reset exits it.
- OPCode, function3 and function7 are combinational slices of the Instr register. They are stable from EXEC until the next response is captured.
- imem_rsp_valid outside WAIT is dropped without any state change.
- PC arithmetic is unsigned and wraps: PC=32'hFFFF_FFFC gives PCPlus4=32'h0000_0000.
- Reset values:
  - PC=RESET_PC
  - Instr=32'h0000_0013 (NOP)
  - state=IDLE
  - imem_req_valid=0, instr_valid=0, fetch_fault=0
  - imem_req_addr=RESET_PC
- Reset during any state, including mid-WAIT: returns to IDLE. A response to the abandoned request must not be delivered; the instruction memory shares reset_n and is required to cancel it.

## Timing
- Best case, with ready=1 in REQ and the response in the next cycle: 3 cycles per instruction (REQ, WAIT, EXEC).
- The earliest accepted response is the cycle after the request handshake. A same-cycle response is illegal and is ignored.
- imem_req_valid and imem_req_addr are held stable from assertion until imem_req_ready is seen. Valid is never withdrawn without a handshake, except by reset.
- PCsrc and PCTarget are sampled only on the EXEC clock edge.
- State-derived outputs are glitch-free with respect to clk. instr_valid and imem_req_valid are pure decodes of the state register.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, REQ, WAIT, EXEC, FAULT)
  - NOP_INSTR = 32'h0000_0013
  - the field position constants for opcode, funct3 and funct7[5]
  - RESET_PC default
- One combinational sub-module, pc_next_logic, computes next_pc and the misalign flag from PC, PCsrc and PCTarget. The FSM and registers stay in instr_fetch_unit.

## Test plan
- Reset release, ready=1, response in 1 cycle with 32'h0000_0013 → first request addr=0x0. instr_valid pulses in cycle 3 with OPCode=7'h13. The next request addr=0x4.
- imem_req_ready held 0 for 5 cycles → imem_req_valid stays 1 and imem_req_addr stays constant. No WAIT entry until ready=1.
- EXEC with PCsrc=1, PCTarget=0x0000_0100 → next imem_req_addr=0x100 and PCPlus4 becomes 0x104.
- EXEC with PCsrc=1, PCTarget=0x0000_0102 → fetch_fault=1 and no further imem_req_valid. PC stays at its old value until reset_n=0.
- PC=0xFFFF_FFFC with PCsrc=0 → next request addr=0x0000_0000.
- reset_n=0 for one cycle while in WAIT, followed by a stray imem_rsp_valid in IDLE → Instr=32'h13 and instr_valid=0. A new request is issued at RESET_PC.
